// File: rtl/tick_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tick_scheduler
// Brief    : Four requesters share one prescaled delay timer. Ownership is
//            granted round-robin. Define FAST_SIM_EN to make the prescaler
//            fire a tick on every counting cycle.
// Revision : 1.0 - initial release
// =============================================================================
module tick_scheduler #(
    parameter int unsigned PRESCALE = 12000000,
    parameter int unsigned DW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] req_delay,
    output logic [3:0]      gnt,
    output logic [3:0]      done,
    output logic            busy,
    output logic            tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef FAST_SIM_EN
    localparam logic [31:0] c_term_count = 32'd0;
`else
    localparam logic [31:0] c_term_count = 32'(PRESCALE - 1);
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_prescale;
    logic [31:0]     w_prescale_nxt;
    logic [DW-1:0]   r_remaining;
    logic [DW-1:0]   w_remaining_nxt;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_nxt;
    logic [1:0]      r_last;
    logic [1:0]      w_last_nxt;
    logic [3:0]      w_gnt_nxt;
    logic [3:0]      w_done_nxt;
    logic            w_busy_nxt;
    logic            w_tick_nxt;
    logic [1:0]      w_win;
    logic [1:0]      w_probe;
    logic            w_found;
    logic [DW-1:0]   w_win_delay;

    // Search starts one past the last winner; offset 4 wraps back onto it.
    always_comb begin
        w_win   = r_last;
        w_probe = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_probe = r_last + 2'(k);
            if (!w_found && req[w_probe]) begin
                w_win   = w_probe;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_delay = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_win == 2'(i)) begin
                w_win_delay = req_delay[DW*i +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prescale_nxt  = r_prescale;
        w_remaining_nxt = r_remaining;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_gnt_nxt       = gnt;
        w_done_nxt      = 4'd0;

        case (r_state)
            IDLE: begin
                if (req != 4'd0) begin
                    w_owner_nxt     = w_win;
                    w_gnt_nxt       = 4'b0001 << w_win;
                    w_remaining_nxt = w_win_delay;
                    w_prescale_nxt  = 32'd0;
                    if (w_win_delay == '0) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 4'b0001 << w_win;
                        w_last_nxt  = w_win;
                    end else begin
                        w_state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (r_prescale == c_term_count) begin
                    w_prescale_nxt  = 32'd0;
                    w_remaining_nxt = r_remaining - DW'(1);
                    if (r_remaining == DW'(1)) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 4'b0001 << r_owner;
                        w_last_nxt  = r_owner;
                    end
                end else begin
                    w_prescale_nxt = r_prescale + 32'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'd0;
            end
        endcase

        // Outputs are registered, so tick and busy are derived from next state.
        w_busy_nxt = (w_state_nxt != IDLE);
        w_tick_nxt = (w_state_nxt == COUNT) && (w_prescale_nxt == c_term_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prescale  <= 32'd0;
            r_remaining <= '0;
            r_owner     <= 2'd0;
            r_last      <= 2'd3;
            gnt         <= 4'd0;
            done        <= 4'd0;
            busy        <= 1'b0;
            tick        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prescale  <= w_prescale_nxt;
            r_remaining <= w_remaining_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            gnt         <= w_gnt_nxt;
            done        <= w_done_nxt;
            busy        <= w_busy_nxt;
            tick        <= w_tick_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 12000000: clk cycles per timer tick, legal range >= 1.
REQ-002 SHALL have parameter DW, default 8: delay field width in ticks.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  4  per-channel level request, held by the requester until its done pulse.
REQ-006 SHALL have port req_delay  input  4*DW  channel i delay in ticks at bits [DW*i+DW-1 : DW*i].
REQ-007 SHALL have port gnt  output  4  one-hot owner of the shared timer; all zero when idle.
REQ-008 SHALL have port done  output  4  one-cycle expiry pulse to the owning channel.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port tick  output  1  one-cycle prescaler terminal-count pulse, for debug.

Function
REQ-011 SHALL implement FSM states IDLE, COUNT and DONE; all outputs are registered.
REQ-012 In IDLE with req != 0, the next edge SHALL:
- set gnt to the round-robin winner;
- latch the winner's req_delay into a DW-bit remaining counter;
- clear the prescaler;
- go to COUNT, or to DONE if the latched delay is 0.
REQ-013 Round-robin SHALL search from (last winner + 1) mod 4 upward and wrap; the last-winner pointer updates on entry to DONE.
REQ-014 The prescaler SHALL be a 32-bit counter that runs only in COUNT, counts 0..PRESCALE-1 and wraps, and asserts tick on the cycle it equals PRESCALE-1.
REQ-015 On each tick in COUNT, remaining SHALL decrement by one; a tick with remaining == 1 SHALL move the FSM to DONE.
REQ-016 In DONE for exactly one cycle, done[winner] SHALL be high and gnt held; the next edge SHALL clear gnt and return to IDLE.
REQ-017 For delay D >= 1, gnt SHALL be high for D*PRESCALE+1 cycles; for D = 0, for 1 cycle (the DONE cycle).
REQ-018 Grant latency SHALL be one edge from req sampled high in IDLE; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-019 req deassertion or req_delay change after grant SHALL be ignored; the running delay completes (no cancel).
REQ-020 A requester still asserting req in the IDLE cycle after its done SHALL be re-eligible at rotated priority.
REQ-021 Requests arriving during COUNT or DONE SHALL wait, with no loss, and be arbitrated in the next IDLE cycle.
REQ-022 Simultaneous requests SHALL yield exactly one gnt bit; gnt and done SHALL never have more than one bit set.

Reset
REQ-023 While rst is high, the block SHALL hold: state = IDLE, gnt = 0, done = 0, busy = 0, tick = 0, prescaler = 0, remaining = 0, last-winner pointer = 3 (channel 0 has first priority).
REQ-024 rst asserted mid-COUNT or mid-DONE SHALL abort immediately, with no done pulse, then or after release.
REQ-025 The first arbitration SHALL occur on the first edge after rst deasserts with req != 0.

Configuration
REQ-026 Macro FAST_SIM_EN:
- defined: prescaler terminal count fixed to 0, so tick fires every COUNT cycle (PRESCALE ignored, effective PRESCALE = 1), for simulation;
- undefined: PRESCALE as parameterised.

Verification (FAST_SIM_EN defined unless stated)
REQ-027 req=0001, delay0=3 -> gnt=0001 from edge 1 for 4 cycles, done=0001 pulse in 4th cycle, busy matches gnt.
REQ-028 req=1111 held, all delays 1 -> grants in order 0,1,2,3,0; each done on its own channel; one IDLE gap between grants.
REQ-029 req=0010, delay1=0 -> gnt=0010 and done=0010 together for one cycle, never in COUNT.
REQ-030 req=0001, delay0=200; rst pulsed at cycle 50 -> all outputs 0 in the same cycle, no done ever, next grant restarts at channel 0.
REQ-031 FAST_SIM_EN undefined, PRESCALE=4, delay2=2, req=0100 -> tick every 4th COUNT cycle, gnt high 9 cycles, done on 9th.
REQ-032 req2 dropped and delay2 changed mid-COUNT -> original delay completes, done=0100 issued.
